// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Used by mem_port_arbiter and mem_port_rr_pick.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    localparam int LINE_W     = 256;
    localparam int ADDR_W_DEF = 32;

    // Saturating 32-bit event counter step.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/mem_port_rr_pick.sv
// Combinational 2-way picker: round-robin against the last winner, or fixed
// priority with dcache winning ties.
module mem_port_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic ic_req_i,
    input  logic dc_req_i,
    input  logic last_i,
    input  logic rr_en_i,
    output logic winner_o
);

    always_comb begin
        winner_o = GNT_IC;
        if (ic_req_i && dc_req_i) begin
            winner_o = rr_en_i ? ~last_i : GNT_DC;
        end else if (dc_req_i) begin
            winner_o = GNT_DC;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache and dcache: IDLE -> BUSY -> GAP per
// transaction. Optional perf counters enabled by MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = LINE_W,
    parameter int RR_EN_PARAM = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_i,
    input  logic              ic_write_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic [DATA_W-1:0] ic_data_i,
    output logic              ic_ack_o,
    input  logic              dc_req_i,
    input  logic              dc_write_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [DATA_W-1:0] dc_data_i,
    output logic              dc_ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
`ifdef MEM_PORT_ARBITER_PERF_EN
    output logic [31:0]       perf_ic_grants_o,
    output logic [31:0]       perf_dc_grants_o,
    output logic [31:0]       perf_wait_cycles_o,
`endif
    output logic              busy_o,
    output logic              grant_o
);

    arb_state_e        state_q, state_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              busy_q, busy_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              winner;
    logic              start_txn;

    mem_port_rr_pick u_pick (
        .ic_req_i (ic_req_i),
        .dc_req_i (dc_req_i),
        .last_i   (last_q),
        .rr_en_i  (RR_EN_PARAM != 0),
        .winner_o (winner)
    );

    assign start_txn = (state_q == ST_IDLE) && (ic_req_i || dc_req_i);

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        busy_d       = busy_q;
        grant_d      = grant_q;
        last_d       = last_q;
        case (state_q)
            ST_IDLE: begin
                if (start_txn) begin
                    state_d      = ST_BUSY;
                    grant_d      = winner;
                    mem_enable_d = 1'b1;
                    busy_d       = 1'b1;
                    mem_write_d  = (winner == GNT_DC) ? dc_write_i : ic_write_i;
                    mem_addr_d   = (winner == GNT_DC) ? dc_addr_i  : ic_addr_i;
                    mem_data_d   = (winner == GNT_DC) ? dc_data_i  : ic_data_i;
                end
            end
            ST_BUSY: begin
                // Command stays latched; requester inputs are ignored until the ack.
                if (mem_ack_i) begin
                    state_d      = ST_GAP;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    busy_d       = 1'b0;
                    last_d       = grant_q;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            busy_q       <= 1'b0;
            grant_q      <= GNT_IC;
            last_q       <= GNT_IC;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
        end
    end

    assign ic_ack_o     = mem_ack_i && (state_q == ST_BUSY) && (grant_q == GNT_IC);
    assign dc_ack_o     = mem_ack_i && (state_q == ST_BUSY) && (grant_q == GNT_DC);
    assign rdata_o      = mem_data_i;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign busy_o       = busy_q;
    assign grant_o      = grant_q;

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] ic_grants_q, ic_grants_d;
    logic [31:0] dc_grants_q, dc_grants_d;
    logic [31:0] wait_q, wait_d;
    logic        ic_owns, dc_owns, any_wait;

    assign ic_owns  = (state_q == ST_BUSY) && (grant_q == GNT_IC);
    assign dc_owns  = (state_q == ST_BUSY) && (grant_q == GNT_DC);
    assign any_wait = (ic_req_i && !ic_owns) || (dc_req_i && !dc_owns);

    always_comb begin
        ic_grants_d = sat_inc(ic_grants_q, start_txn && (winner == GNT_IC));
        dc_grants_d = sat_inc(dc_grants_q, start_txn && (winner == GNT_DC));
        wait_d      = sat_inc(wait_q, any_wait);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ic_grants_q <= '0;
            dc_grants_q <= '0;
            wait_q      <= '0;
        end else begin
            ic_grants_q <= ic_grants_d;
            dc_grants_q <= dc_grants_d;
            wait_q      <= wait_d;
        end
    end

    assign perf_ic_grants_o   = ic_grants_q;
    assign perf_dc_grants_o   = dc_grants_q;
    assign perf_wait_cycles_o = wait_q;
`endif

endmodule
